// File: rtl/aes_sbox_lane_sched_if.sv
// Requester-side bundle for the shared SubBytes lane scheduler.
// Block i of every wide bus sits at [i*128 +: 128].
interface aes_sbox_lane_sched_if #(
  parameter int N_REQ = 16
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*128-1:0] req_data;
  logic [N_REQ-1:0]     rsp_valid;
  logic [N_REQ-1:0]     rsp_ready;
  logic [N_REQ*128-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/aes_sbox_lane_sched.sv
// Ten-lane SubBytes datapath shared round-robin between N_REQ requesters.
// Grant in cycle t, lane register in t+1, held response visible in t+2.
module aes_sbox (
  input  logic [127:0] in_block,
  output logic [127:0] out_block
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign out_block[b*8 +: 8] = SBOX[in_block[b*8 +: 8]];
  end
endmodule

module aes_sbox_lane_sched #(
  parameter int N_REQ = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_sbox_lane_sched_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  localparam int N_LANE = 10;
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     busy;
  logic [N_REQ-1:0]     rsp_valid_q;
  logic [N_REQ*128-1:0] rsp_data_q;
  logic [N_REQ-1:0]     hs;
  logic [N_REQ-1:0]     eligible;
  logic [N_REQ-1:0]     grant;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      rr_next;
  logic                 stall;

  logic                 sel_vld   [N_LANE];
  logic [ID_W-1:0]      sel_id    [N_LANE];
  logic                 lane_vld  [N_LANE];
  logic [ID_W-1:0]      lane_id   [N_LANE];
  logic [127:0]         lane_data [N_LANE];
  logic [127:0]         lane_out  [N_LANE];

  int scan_idx;
  int grant_cnt;
  int elig_cnt;

  // A requester whose held response is being taken this cycle may be regranted at once.
  assign hs        = rsp_valid_q & bus.rsp_ready;
  assign eligible  = bus.req_valid & (~busy | hs);
  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Round-robin scan from rr_ptr: first ten eligible requesters fill lanes in scan order.
  always_comb begin
    grant     = '0;
    rr_next   = rr_ptr;
    scan_idx  = 0;
    grant_cnt = 0;
    elig_cnt  = 0;
    for (int k = 0; k < N_LANE; k++) begin
      sel_vld[k] = 1'b0;
      sel_id[k]  = '0;
    end
    for (int off = 0; off < N_REQ; off++) begin
      scan_idx = int'(rr_ptr) + off;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (eligible[ID_W'(scan_idx)]) begin
        elig_cnt = elig_cnt + 1;
        if (grant_cnt < N_LANE) begin
          grant[ID_W'(scan_idx)] = 1'b1;
          sel_vld[grant_cnt]     = 1'b1;
          sel_id[grant_cnt]      = ID_W'(scan_idx);
          grant_cnt              = grant_cnt + 1;
          rr_next = (scan_idx == N_REQ - 1) ? '0 : ID_W'(scan_idx + 1);
        end
      end
    end
    stall = (elig_cnt > grant_cnt);
  end

  // Scheduler state: pointer, one-outstanding tracking and saturating stall count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      busy      <= '0;
      stall_cnt <= '0;
    end else begin
      rr_ptr <= rr_next;
      busy   <= (busy & ~hs) | grant;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Lane registers capture granted blocks; idle lanes are zeroed so the S-boxes see 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_LANE; k++) begin
        lane_vld[k]  <= 1'b0;
        lane_id[k]   <= '0;
        lane_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_LANE; k++) begin
        lane_vld[k]  <= sel_vld[k];
        lane_id[k]   <= sel_id[k];
        lane_data[k] <= sel_vld[k] ? bus.req_data[int'(sel_id[k])*128 +: 128] : '0;
      end
    end
  end

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    aes_sbox u_sbox (
      .in_block  (lane_data[k]),
      .out_block (lane_out[k])
    );
  end

  // Responses hold until taken; a result landing at the same edge as a handshake wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_q & ~hs;
      for (int k = 0; k < N_LANE; k++) begin
        if (lane_vld[k]) begin
          rsp_valid_q[lane_id[k]]                   <= 1'b1;
          rsp_data_q[int'(lane_id[k])*128 +: 128]   <= lane_out[k];
        end
      end
    end
  end
endmodule
